samp_timing_gen: RTL and testbench
==================================

SAMP_TIMING_GEN -- requirements
Module: samp_timing_gen

Interface
REQ-001 Parameter: CNT_W, 8, width of sample-window length counter (min 2).
REQ-002 Parameter: CONV_W, 4, width of conversion-cycle counter and index (min 2).
REQ-003 clk_in  input  1  single block clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  conversion request, sampled each rising edge.
REQ-006 abort  input  1  synchronous abort of any conversion in progress.
REQ-007 cont  input  1  continuous mode: re-enter SAMPLE after DONE.
REQ-008 samp_len  input  CNT_W  sample-window length in clk_in cycles; 0 treated as 1.
REQ-009 conv_cycles  input  CONV_W  comparator decisions per conversion; 0 treated as 1.
REQ-010 samp  output  1  sampling-clock drive; feeds the sampling clock driver input.
REQ-011 comp_en  output  1  comparator clock enable, high one cycle per decision.
REQ-012 conv_idx  output  CONV_W  index of current decision, 0-based.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse at end of conversion.

Function
REQ-015 FSM states: IDLE, SAMPLE, CONVERT, DONE; all outputs registered, no combinational input-to-output paths.
REQ-016 IDLE: start=1 at edge N -> SAMPLE; samp_len and conv_cycles latched at edge N; samp=1, busy=1 visible after edge N.
REQ-017 SAMPLE: samp=1 for exactly max(samp_len,1) cycles; then CONVERT.
REQ-018 CONVERT: comp_en=1 for exactly max(conv_cycles,1) consecutive cycles; samp=0; conv_idx=0 on first cycle, increments by 1 each cycle; then DONE.
REQ-019 DONE: done=1 for one cycle, samp=0, comp_en=0, conv_idx holds last value; next state SAMPLE if cont=1 (relatching samp_len/conv_cycles), else IDLE.
REQ-020 Inputs samp_len, conv_cycles changing mid-conversion have no effect until next latch.
REQ-021 start while busy=1 ignored; no restart, no queuing.
REQ-022 abort=1 has priority over all transitions: next edge -> IDLE, samp=0, comp_en=0, conv_idx=0, busy=0, no done pulse.
REQ-023 abort and start asserted together in IDLE: abort wins, remain IDLE.
REQ-024 Counters never wrap: samp_len = 2^CNT_W-1 and conv_cycles = 2^CONV_W-1 produce exactly that many cycles.
REQ-025 samp has no glitches: changes only on rising edge of clk_in.

Reset
REQ-026 rst_n=0 immediately forces IDLE, samp=0, comp_en=0, conv_idx=0, busy=0, done=0, latched settings=0, independent of clk_in.
REQ-027 Reset assertion mid-SAMPLE or mid-CONVERT aborts without done; after release, first start behaves per REQ-016.

Configuration
REQ-028 Macro SAMP_TIMING_GEN_OVERRUN_EN defined: add output overrun (1 bit), set sticky when start=1 while busy=1 and abort=0, cleared only by reset or by start accepted in IDLE.
REQ-029 Macro undefined: no overrun port, no overrun logic; all other behaviour identical.

Verification
REQ-030 samp_len=3, conv_cycles=4, cont=0, start pulse at edge 0 -> samp high edges 1-3, comp_en high edges 4-7 with conv_idx 0..3, done at edge 8, busy low after edge 9.
REQ-031 samp_len=0, conv_cycles=0 -> samp 1 cycle, comp_en 1 cycle, done pulse; total busy 3 cycles.
REQ-032 cont=1, samp_len=2, conv_cycles=2 -> repeating period of 5 cycles (2 samp, 2 comp_en, 1 done) until cont=0 after a DONE, then IDLE.
REQ-033 abort during CONVERT at conv_idx=2 -> next edge all outputs 0, no done; later start runs full conversion.
REQ-034 start pulsed in SAMPLE -> ignored, timing unchanged; with SAMP_TIMING_GEN_OVERRUN_EN, overrun=1 and stays 1 until next accepted start.
REQ-035 rst_n low asynchronously mid-SAMPLE -> samp, busy drop before next clk_in edge; samp_len=255, conv_cycles=15 after release -> exactly 255 and 15 cycles.

Source files
------------

// File: rtl/samp_timing_gen_if.sv
// Handshake/bus bundle between a converter controller and samp_timing_gen.
// The overrun flag exists only when SAMP_TIMING_GEN_OVERRUN_EN is defined.
interface samp_timing_gen_if #(
  parameter int CNT_W  = 8,
  parameter int CONV_W = 4
);
  logic              start;
  logic              abort;
  logic              cont;
  logic [CNT_W-1:0]  samp_len;
  logic [CONV_W-1:0] conv_cycles;
  logic              samp;
  logic              comp_en;
  logic [CONV_W-1:0] conv_idx;
  logic              busy;
  logic              done;
`ifdef SAMP_TIMING_GEN_OVERRUN_EN
  logic              overrun;

  modport master (
    output start, abort, cont, samp_len, conv_cycles,
    input  samp, comp_en, conv_idx, busy, done, overrun
  );
  modport slave (
    input  start, abort, cont, samp_len, conv_cycles,
    output samp, comp_en, conv_idx, busy, done, overrun
  );
`else
  modport master (
    output start, abort, cont, samp_len, conv_cycles,
    input  samp, comp_en, conv_idx, busy, done
  );
  modport slave (
    input  start, abort, cont, samp_len, conv_cycles,
    output samp, comp_en, conv_idx, busy, done
  );
`endif
endinterface

// File: rtl/samp_timing_gen.sv
// Sample-window / conversion-cycle timing generator (IDLE -> SAMPLE -> CONVERT -> DONE), all outputs registered.
// Define SAMP_TIMING_GEN_OVERRUN_EN to add the sticky overrun flag for starts requested while busy.
module samp_timing_gen #(
  parameter int CNT_W  = 8,
  parameter int CONV_W = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  samp_timing_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  samp_cnt_q, samp_cnt_d;
  logic [CNT_W-1:0]  samp_len_q, samp_len_d;
  logic [CONV_W-1:0] conv_idx_q, conv_idx_d;
  logic [CONV_W-1:0] conv_cyc_q, conv_cyc_d;
  logic              samp_q, samp_d;
  logic              comp_en_q, comp_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              latch;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      samp_cnt_q <= '0;
      samp_len_q <= '0;
      conv_idx_q <= '0;
      conv_cyc_q <= '0;
      samp_q     <= 1'b0;
      comp_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      samp_len_q <= samp_len_d;
      conv_idx_q <= conv_idx_d;
      conv_cyc_q <= conv_cyc_d;
      samp_q     <= samp_d;
      comp_en_q  <= comp_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Lengths are stored already clamped to >=1, so terminal compares never underflow or wrap.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    conv_idx_d = conv_idx_q;
    latch      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SAMPLE;
          latch   = 1'b1;
        end
      end
      SAMPLE: begin
        if (samp_cnt_q == samp_len_q) begin
          state_d    = CONVERT;
          conv_idx_d = '0;
        end else begin
          samp_cnt_d = samp_cnt_q + CNT_W'(1);
        end
      end
      CONVERT: begin
        if (conv_idx_q == conv_cyc_q - CONV_W'(1)) begin
          state_d = DONE;
        end else begin
          conv_idx_d = conv_idx_q + CONV_W'(1);
        end
      end
      DONE: begin
        if (bus.cont) begin
          state_d = SAMPLE;
          latch   = 1'b1;
        end else begin
          state_d    = IDLE;
          conv_idx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (latch) begin
      samp_cnt_d = CNT_W'(1);
      conv_idx_d = '0;
    end
    if (bus.abort) begin
      state_d    = IDLE;
      samp_cnt_d = '0;
      conv_idx_d = '0;
      latch      = 1'b0;
    end
    samp_len_d = samp_len_q;
    conv_cyc_d = conv_cyc_q;
    if (latch) begin
      samp_len_d = (bus.samp_len == '0) ? CNT_W'(1) : bus.samp_len;
      conv_cyc_d = (bus.conv_cycles == '0) ? CONV_W'(1) : bus.conv_cycles;
    end
  end

  always_comb begin
    samp_d    = (state_d == SAMPLE);
    comp_en_d = (state_d == CONVERT);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  assign bus.samp     = samp_q;
  assign bus.comp_en  = comp_en_q;
  assign bus.conv_idx = conv_idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

`ifdef SAMP_TIMING_GEN_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (bus.start && !bus.abort) begin
      overrun_d = (state_q != IDLE);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign bus.overrun = overrun_q;
`endif

endmodule

// File: tb/tb_samp_timing_gen.sv
// Directed bench for samp_timing_gen: per-edge output vectors against hand-derived timing.
module tb_samp_timing_gen;
  localparam int CNT_W  = 8;
  localparam int CONV_W = 4;
  localparam int VW     = CONV_W + 4;

  logic clk_in;
  logic rst_n;
  int   total;
  int   bad;

  samp_timing_gen_if #(.CNT_W(CNT_W), .CONV_W(CONV_W)) bus ();

  samp_timing_gen #(.CNT_W(CNT_W), .CONV_W(CONV_W)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  // {samp, comp_en, conv_idx, busy, done}
  function automatic logic [VW-1:0] obs();
    return {bus.samp, bus.comp_en, bus.conv_idx, bus.busy, bus.done};
  endfunction

  // Expected outputs after edge e of a single run started so that edge 1 enters SAMPLE.
  function automatic logic [VW-1:0] golden(int e, int s, int c);
    int se = (s == 0) ? 1 : s;
    int ce = (c == 0) ? 1 : c;
    logic es, ec, eb, ed;
    logic [CONV_W-1:0] ei;
    es = (e >= 1) && (e <= se);
    ec = (e > se) && (e <= se + ce);
    ed = (e == se + ce + 1);
    eb = (e >= 1) && (e <= se + ce + 1);
    ei = ec ? CONV_W'(e - se - 1) : (ed ? CONV_W'(ce - 1) : '0);
    return {es, ec, ei, eb, ed};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic start_run(int s, int c);
    bus.samp_len    = CNT_W'(s);
    bus.conv_cycles = CONV_W'(c);
    bus.start       = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.cont = 1'b0;
    bus.samp_len = '0; bus.conv_cycles = '0;
    tick();
    total++;
    if (obs() !== '0) begin
      bad++; $display("FAIL reset_state got=%b exp=%b", obs(), {VW{1'b0}});
    end
`ifdef SAMP_TIMING_GEN_OVERRUN_EN
    total++;
    if (bus.overrun !== 1'b0) begin
      bad++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun);
    end
`endif
    @(negedge clk_in);
    rst_n = 1'b1;
    tick(); tick();
    total++;
    if (obs() !== '0) begin
      bad++; $display("FAIL idle_after_release got=%b exp=%b", obs(), {VW{1'b0}});
    end
  endtask

  task automatic test_basic();
    bus.cont = 1'b0;
    start_run(3, 4);
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 1) bus.start = 1'b0;
      total++;
      if (obs() !== golden(e, 3, 4)) begin
        bad++; $display("FAIL basic e=%0d got=%b exp=%b", e, obs(), golden(e, 3, 4));
      end
    end
  endtask

  task automatic test_min();
    start_run(0, 0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 1) bus.start = 1'b0;
      total++;
      if (obs() !== golden(e, 0, 0)) begin
        bad++; $display("FAIL min_len e=%0d got=%b exp=%b", e, obs(), golden(e, 0, 0));
      end
    end
  endtask

  task automatic test_latch();
    start_run(2, 3);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 1) begin
        bus.start = 1'b0;
        bus.samp_len = CNT_W'(9);
        bus.conv_cycles = CONV_W'(1);
      end
      total++;
      if (obs() !== golden(e, 2, 3)) begin
        bad++; $display("FAIL latch e=%0d got=%b exp=%b", e, obs(), golden(e, 2, 3));
      end
    end
  endtask

  task automatic test_cont();
    logic [VW-1:0] exp_v;
    bus.cont = 1'b1;
    start_run(2, 2);
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (e == 1) bus.start = 1'b0;
      if (e == 15) bus.cont = 1'b0;
      exp_v = (e <= 15) ? golden(((e - 1) % 5) + 1, 2, 2) : '0;
      total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL cont e=%0d got=%b exp=%b", e, obs(), exp_v);
      end
    end
  endtask

  task automatic test_abort();
    start_run(1, 4);
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 1) bus.start = 1'b0;
      if (e == 4) bus.abort = 1'b1;
      if (e == 5) bus.abort = 1'b0;
      total++;
      if (e <= 4 && obs() !== golden(e, 1, 4)) begin
        bad++; $display("FAIL abort_pre e=%0d got=%b exp=%b", e, obs(), golden(e, 1, 4));
      end else if (e > 4 && obs() !== '0) begin
        bad++; $display("FAIL abort_post e=%0d got=%b exp=%b", e, obs(), {VW{1'b0}});
      end
    end
    start_run(1, 2);
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 1) bus.start = 1'b0;
      total++;
      if (obs() !== golden(e, 1, 2)) begin
        bad++; $display("FAIL after_abort e=%0d got=%b exp=%b", e, obs(), golden(e, 1, 2));
      end
    end
    bus.abort = 1'b1;
    start_run(3, 3);
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      total++;
      if (obs() !== '0) begin
        bad++; $display("FAIL abort_start_idle e=%0d got=%b exp=%b", e, obs(), {VW{1'b0}});
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    start_run(3, 2);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 1) bus.start = 1'b0;
      if (e == 2) bus.start = 1'b1;
      if (e == 3) bus.start = 1'b0;
      total++;
      if (obs() !== golden(e, 3, 2)) begin
        bad++; $display("FAIL ignore_start e=%0d got=%b exp=%b", e, obs(), golden(e, 3, 2));
      end
`ifdef SAMP_TIMING_GEN_OVERRUN_EN
      total++;
      if (bus.overrun !== (e >= 3)) begin
        bad++; $display("FAIL overrun_set e=%0d got=%b exp=%b", e, bus.overrun, (e >= 3));
      end
`endif
    end
    start_run(1, 1);
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 1) bus.start = 1'b0;
      total++;
      if (obs() !== golden(e, 1, 1)) begin
        bad++; $display("FAIL restart e=%0d got=%b exp=%b", e, obs(), golden(e, 1, 1));
      end
`ifdef SAMP_TIMING_GEN_OVERRUN_EN
      total++;
      if (bus.overrun !== 1'b0) begin
        bad++; $display("FAIL overrun_clear e=%0d got=%b exp=0", e, bus.overrun);
      end
`endif
    end
  endtask

  task automatic test_async_reset_max();
    int samp_n = 0, comp_n = 0, done_n = 0, first_comp = 0;
    logic [CONV_W-1:0] last_idx = '0;
    bit finished = 1'b0;
    start_run(5, 2);
    tick();
    bus.start = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== '0) begin
      bad++; $display("FAIL async_reset got=%b exp=%b", obs(), {VW{1'b0}});
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    tick();
    total++;
    if (obs() !== '0) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=%b", obs(), {VW{1'b0}});
    end
    start_run(255, 15);
    for (int e = 1; e <= 300 && !finished; e++) begin
      tick();
      if (e == 1) bus.start = 1'b0;
      if (bus.samp) samp_n++;
      if (bus.comp_en) begin
        comp_n++;
        last_idx = bus.conv_idx;
        if (first_comp == 0) first_comp = e;
      end
      if (bus.done) done_n++;
      if (e > 1 && !bus.busy) finished = 1'b1;
    end
    total++;
    if (!finished) begin
      bad++; $display("FAIL max_timeout got=busy exp=idle within 300 edges");
    end
    total++;
    if (samp_n != 255) begin
      bad++; $display("FAIL max_samp_cycles got=%0d exp=255", samp_n);
    end
    total++;
    if (comp_n != 15) begin
      bad++; $display("FAIL max_comp_cycles got=%0d exp=15", comp_n);
    end
    total++;
    if (first_comp != 256) begin
      bad++; $display("FAIL max_first_comp got=%0d exp=256", first_comp);
    end
    total++;
    if (last_idx !== CONV_W'(14)) begin
      bad++; $display("FAIL max_last_idx got=%0d exp=14", last_idx);
    end
    total++;
    if (done_n != 1) begin
      bad++; $display("FAIL max_done_pulses got=%0d exp=1", done_n);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_min();
    test_latch();
    test_cont();
    test_abort();
    test_ignore_start();
    test_async_reset_max();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
